// File: rtl/layer12_pkg.sv
// Shared constants and types for the layer-12 sequencer.
// Per-pass tables are indexed by pass number u (0..4).
// Pure package: no logic, no timing.
package layer12_pkg;

  localparam int NPASS = 5;
  localparam int PIX   = 64;

  typedef enum logic [1:0] {
    KDIR_1X1 = 2'd0,
    KDIR_1X3 = 2'd1,
    KDIR_3X1 = 2'd2
  } kdir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Element [u] belongs to pass u (element 0 is the rightmost entry).
  localparam logic [NPASS-1:0][1:0] CIN_TAB  = {2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
  localparam logic [NPASS-1:0][1:0] COUT_TAB = {2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
  localparam logic [NPASS-1:0][1:0] KDIR_TAB = {KDIR_1X1, KDIR_3X1, KDIR_1X3,
                                                KDIR_1X1, KDIR_1X1};

  function automatic logic [1:0] cin_of(input logic [2:0] u);
    return (u < 3'(NPASS)) ? CIN_TAB[u] : 2'd1;
  endfunction

  function automatic logic [1:0] cout_of(input logic [2:0] u);
    return (u < 3'(NPASS)) ? COUT_TAB[u] : 2'd1;
  endfunction

  function automatic kdir_e kdir_of(input logic [2:0] u);
    return (u < 3'(NPASS)) ? kdir_e'(KDIR_TAB[u]) : KDIR_1X1;
  endfunction

  // Taps per pixel and input tile: one for pointwise, three otherwise.
  function automatic logic [1:0] kt_of(input kdir_e k);
    return (k == KDIR_1X1) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/layer12_addr_gen.sv
// Combinational read / write / skip address and padding generation.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs are gated to 0 by the enable inputs.
// Ports: kdir_i/cin_i/tap_i/pix_i describe the tap being issued (rd_en_i),
//        wz_i/wpix_i describe the pixel being written (wr_en_i, skip_en_i).
module layer12_addr_gen
  import layer12_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int W      = 8,
  parameter int H      = 8,
  parameter int PIX_W  = 6
) (
  input  kdir_e             kdir_i,
  input  logic              rd_en_i,
  input  logic [1:0]        cin_i,
  input  logic [1:0]        tap_i,
  input  logic [PIX_W-1:0]  pix_i,
  input  logic              wr_en_i,
  input  logic              skip_en_i,
  input  logic [2:0]        wz_i,
  input  logic [PIX_W-1:0]  wpix_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] skip_addr_o,
  output logic              pad_o
);

  int   x_c, y_c, nb_c, src_c;
  logic pad_c;

  always_comb begin
    x_c   = int'(pix_i) % W;
    y_c   = int'(pix_i) / W;
    nb_c  = 0;
    src_c = int'(pix_i);
    pad_c = 1'b0;
    unique case (kdir_i)
      KDIR_1X3: begin
        // Horizontal neighbour: column x+tap-1 must stay inside the row.
        nb_c  = x_c + int'(tap_i) - 1;
        pad_c = (nb_c < 0) || (nb_c >= W);
        src_c = int'(pix_i) + int'(tap_i) - 1;
      end
      KDIR_3X1: begin
        nb_c  = y_c + int'(tap_i) - 1;
        pad_c = (nb_c < 0) || (nb_c >= H);
        src_c = int'(pix_i) + (int'(tap_i) - 1) * W;
      end
      default: begin
        nb_c  = 0;
        src_c = int'(pix_i);
        pad_c = 1'b0;
      end
    endcase
  end

  // A padded tap reads address 0; the datapath substitutes zero via padding.
  assign rd_addr_o   = (rd_en_i && !pad_c) ? ADDR_W'(int'(cin_i) * W * H + src_c) : '0;
  assign pad_o       = rd_en_i && pad_c;
  assign wr_addr_o   = wr_en_i ? ADDR_W'(int'(wz_i) * W * H + int'(wpix_i)) : '0;
  assign skip_addr_o = skip_en_i ? wr_addr_o : '0;

endmodule

// File: rtl/layer12_sequencer.sv
// Layer-12 sequencer: runs the five convolution passes on one start pulse.
// Latency: addresses combinational from state; padding/temp_zero_new/load one cycle later.
// Backpressure: none by default; with SEQ_HOLD_EN, hold freezes everything.
// Ports: clk, rst (async active-low), start -> busy, done, u, z, weight_addr,
//        BRAM1/BRAM2/BRAM_skip address pairs, padding, temp_zero_new, load.
//        Optional feature macro: SEQ_HOLD_EN adds the hold input.
module layer12_sequencer
  import layer12_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int W       = 8,
  parameter int H       = 8,
  parameter int WADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef SEQ_HOLD_EN
  input  logic               hold,
`endif
  output logic               busy,
  output logic               done,
  output logic [2:0]         u,
  output logic [2:0]         z,
  output logic [WADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0]  BRAM1_addr1,
  output logic [ADDR_W-1:0]  BRAM1_addr2,
  output logic [ADDR_W-1:0]  BRAM2_addr1,
  output logic [ADDR_W-1:0]  BRAM2_addr2,
  output logic [ADDR_W-1:0]  BRAM_skip_addr1,
  output logic [ADDR_W-1:0]  BRAM_skip_addr2,
  output logic               padding,
  output logic               temp_zero_new,
  output logic               load
);

  localparam int NPIX  = W * H;
  localparam int PIX_W = $clog2(NPIX);

  logic hold_w;
`ifdef SEQ_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [2:0]         u_q, u_d, z_q, z_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [1:0]         cin_q, cin_d, tap_q, tap_d;
  logic               idle_q, idle_d;     // the spare cycle closing each pixel slot
  // One-stage delay pipeline: write pixel and controls lag the issue by one cycle.
  logic [2:0]         wz_q;
  logic [PIX_W-1:0]   wpix_q;
  logic               pad_q, tzn_q, load_q;

  logic [1:0]         cin_n, cout_n, kt;
  kdir_e              kdir;
  logic               issue, wr_en, pad_c;
  logic [ADDR_W-1:0]  rd_addr, wr_addr, skip_addr;

  assign cin_n  = cin_of(u_q);
  assign cout_n = cout_of(u_q);
  assign kdir   = kdir_of(u_q);
  assign kt     = kt_of(kdir);
  assign issue  = (state_q == RUN) && !idle_q;
  // DRAIN still carries the last pixel's write and load.
  assign wr_en  = (state_q == RUN) || (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    z_d     = z_q;
    pix_d   = pix_q;
    cin_d   = cin_q;
    tap_d   = tap_q;
    idle_d  = idle_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          u_d     = '0;
          z_d     = '0;
          pix_d   = '0;
          cin_d   = '0;
          tap_d   = '0;
          idle_d  = 1'b0;
        end
      end
      RUN: begin
        if (idle_q) begin
          idle_d = 1'b0;
          if (pix_q == PIX_W'(NPIX - 1)) begin
            pix_d = '0;
            if (z_q == 3'(cout_n) - 3'd1) begin
              z_d     = '0;
              state_d = DRAIN;
            end else begin
              z_d = z_q + 3'd1;
            end
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end else if (tap_q == kt - 2'd1) begin
          tap_d = '0;
          if (cin_q == cin_n - 2'd1) begin
            cin_d  = '0;
            idle_d = 1'b1;
          end else begin
            cin_d = cin_q + 2'd1;
          end
        end else begin
          tap_d = tap_q + 2'd1;
        end
      end
      DRAIN: begin
        if (u_q == 3'd4) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          u_d     = u_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        u_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      z_q     <= '0;
      pix_q   <= '0;
      cin_q   <= '0;
      tap_q   <= '0;
      idle_q  <= 1'b0;
      wz_q    <= '0;
      wpix_q  <= '0;
      pad_q   <= 1'b0;
      tzn_q   <= 1'b0;
      load_q  <= 1'b0;
    end else if (!hold_w) begin
      state_q <= state_d;
      u_q     <= u_d;
      z_q     <= z_d;
      pix_q   <= pix_d;
      cin_q   <= cin_d;
      tap_q   <= tap_d;
      idle_q  <= idle_d;
      wz_q    <= z_q;
      wpix_q  <= pix_q;
      pad_q   <= pad_c;
      tzn_q   <= issue && (cin_q == 2'd0) && (tap_q == 2'd0);
      // The cycle after a slot's spare cycle writes that slot's pixel.
      load_q  <= (state_q == RUN) && idle_q;
    end
  end

  layer12_addr_gen #(
    .ADDR_W (ADDR_W),
    .W      (W),
    .H      (H),
    .PIX_W  (PIX_W)
  ) u_addr_gen (
    .kdir_i      (kdir),
    .rd_en_i     (issue),
    .cin_i       (cin_q),
    .tap_i       (tap_q),
    .pix_i       (pix_q),
    .wr_en_i     (wr_en),
    .skip_en_i   (wr_en && (u_q == 3'd4)),
    .wz_i        (wz_q),
    .wpix_i      (wpix_q),
    .rd_addr_o   (rd_addr),
    .wr_addr_o   (wr_addr),
    .skip_addr_o (skip_addr),
    .pad_o       (pad_c)
  );

  assign weight_addr = issue ?
      WADDR_W'((int'(z_q) * int'(cin_n) + int'(cin_q)) * int'(kt) + int'(tap_q)) : '0;

  // Odd passes read memory2 and write memory1; even passes the reverse.
  assign BRAM1_addr1     = u_q[0] ? wr_addr : rd_addr;
  assign BRAM1_addr2     = BRAM1_addr1;
  assign BRAM2_addr1     = u_q[0] ? rd_addr : wr_addr;
  assign BRAM2_addr2     = BRAM2_addr1;
  assign BRAM_skip_addr1 = skip_addr;
  assign BRAM_skip_addr2 = skip_addr;

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE) && !hold_w;
  assign u             = u_q;
  assign z             = z_q;
  assign padding       = pad_q;
  assign temp_zero_new = tzn_q && !hold_w;
  assign load          = load_q && !hold_w;

endmodule
